svm_feature_packer: RTL

//  AXI-Stream width converter and framer that feeds the SVM accelerator's feature slave port.

---
 rtl/svm_feature_packer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/svm_feature_packer.sv
// Packs 32-bit AXI-Stream words into NUM_FEATURES-wide vector beats, zero-padding short packets.
// Optional SVM_PACK_ERR_CNT_EN enables the saturating short-packet counter on err_count.
`timescale 1ns/1ps

module svm_feature_packer #(
    parameter int NUM_FEATURES         = 8,
    parameter int DATA_WIDTH           = 16,
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_M_AXIS_TDATA_WIDTH = NUM_FEATURES * DATA_WIDTH
) (
    input  logic                            axi_clk,
    input  logic                            axi_reset_n,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            err_short_pkt,
    input  logic                            err_clear,
    output logic [15:0]                     err_count
);

    localparam int WORDS = C_M_AXIS_TDATA_WIDTH / C_S_AXIS_TDATA_WIDTH;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t                                        r_state;
    state_t                                        w_state_next;
    logic [CW-1:0]                                 r_word_cnt;
    logic [WORDS-1:0][C_S_AXIS_TDATA_WIDTH-1:0]    r_asm;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]               r_out_data;
    logic                                          r_out_last;
    logic                                          r_err;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]               w_vec;
    logic                                          w_stall;
    logic                                          w_acc;
    logic                                          w_done;
    logic                                          w_short;

    // A word that would complete a vector (final slot or tlast) must wait while the output is stalled.
    assign w_stall       = (r_state == ST_FULL) & ~m_axis_tready;
    assign s_axis_tready = ~(w_stall & ((r_word_cnt == LAST) | s_axis_tlast));
    assign w_acc         = s_axis_tvalid & s_axis_tready;
    assign w_done        = w_acc & ((r_word_cnt == LAST) | s_axis_tlast);
    assign w_short       = w_done & s_axis_tlast & (r_word_cnt != LAST);

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_slot
            assign w_vec[gi*C_S_AXIS_TDATA_WIDTH +: C_S_AXIS_TDATA_WIDTH] =
                (CW'(gi) == r_word_cnt) ? s_axis_tdata :
                (CW'(gi) <  r_word_cnt) ? r_asm[gi]    : '0;
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_done) w_state_next = ST_FULL;
            ST_FULL:  if (!w_done && m_axis_tready) w_state_next = ST_EMPTY;
            default:  w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_state    <= ST_EMPTY;
            r_word_cnt <= '0;
            r_asm      <= '0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_done) begin
                r_out_data <= w_vec;
                r_out_last <= s_axis_tlast;
                r_word_cnt <= '0;
                r_asm      <= '0;
            end else if (w_acc) begin
                r_asm[r_word_cnt] <= s_axis_tdata;
                r_word_cnt        <= r_word_cnt + 1'b1;
            end
        end
    end

    // Clear has priority over a short-packet set in the same cycle.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_err <= 1'b0;
        end else if (err_clear) begin
            r_err <= 1'b0;
        end else if (w_short) begin
            r_err <= 1'b1;
        end
    end

`ifdef SVM_PACK_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_err_cnt <= '0;
        end else if (err_clear) begin
            r_err_cnt <= '0;
        end else if (w_short && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = 16'd0;
`endif

    assign m_axis_tvalid = (r_state == ST_FULL);
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tlast  = r_out_last;
    assign err_short_pkt = r_err;

endmodule
